freq_meter: RTL

Downstream measurement stage for the gate-level frequency divider. It takes the divider output `q_out` on `sig_in`, synchronizes it into the `clk` domain and detects its rising edges. It then counts those edges over a fixed gate window of `GATE_CYCLES` clocks and reports the count with a one-cycle valid strobe. It is used to check the divide ratio in-system and on the bench.

---
 rtl/freq_meter_pkg.sv | 8 +
 rtl/sync_edge_det.sv | 24 ++
 rtl/freq_meter.sv | 92 +++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types for the frequency meter: measurement FSM state encoding.
package freq_meter_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_t;
endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input plus rising-edge detect.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_p,
  input  logic d,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      sync_q <= '0;
      hist   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      hist   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist;
endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous signal over a fixed gate window
// and reports the count with a one-cycle valid strobe.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 1024,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             overflow
);
  localparam int GW = $clog2(GATE_CYCLES);

  state_t           state, state_nxt;
  logic             rise;
  logic [CNT_W-1:0] edge_cnt, edge_nxt;
  logic             ovf, ovf_nxt;
  logic [GW-1:0]    gate_cnt;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .reset_p(reset_p),
    .d      (sig_in),
    .rise   (rise)
  );

  always_ff @(posedge clk) begin
    if (reset_p) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MEASURE;
      MEASURE: if (gate_cnt == '0) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Edge count including this cycle's rise; saturates and flags instead of wrapping.
  always_comb begin
    edge_nxt = edge_cnt;
    ovf_nxt  = ovf;
    if (rise) begin
      if (&edge_cnt) ovf_nxt  = 1'b1;
      else           edge_nxt = edge_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      edge_cnt    <= '0;
      gate_cnt    <= '0;
      ovf         <= 1'b0;
      count_out   <= '0;
      overflow    <= 1'b0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      case (state)
        IDLE: begin
          edge_cnt <= '0;
          gate_cnt <= GW'(GATE_CYCLES - 1);
          ovf      <= 1'b0;
        end
        MEASURE: begin
          edge_cnt <= edge_nxt;
          ovf      <= ovf_nxt;
          if (gate_cnt != '0) begin
            gate_cnt <= gate_cnt - GW'(1);
          end else begin
            count_out   <= edge_nxt;
            overflow    <= ovf_nxt;
            count_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
endmodule
